// File: rtl/cdma_rx_despreader_if.sv
// Chip-stream input and decoded-word output bundle for the CDMA receive despreader.
// master = chip source / result consumer, slave = despreader.
interface cdma_rx_despreader_if #(
  parameter int CW   = 4,
  parameter int BITS = 4
);
  logic                 chip_valid;
  logic                 chip_sof;
  logic signed [CW-1:0] chip_sum;
  logic [BITS-1:0]      user1_out;
  logic [BITS-1:0]      user2_out;
  logic [BITS-1:0]      user3_out;
  logic [BITS-1:0]      user4_out;
  logic                 out_valid;
  logic                 frame_err;
  logic                 resync;
  logic [7:0]           err_count;

  modport master (
    output chip_valid, chip_sof, chip_sum,
    input  user1_out, user2_out, user3_out, user4_out,
    input  out_valid, frame_err, resync, err_count
  );

  modport slave (
    input  chip_valid, chip_sof, chip_sum,
    output user1_out, user2_out, user3_out, user4_out,
    output out_valid, frame_err, resync, err_count
  );
endinterface

// File: rtl/cdma_rx_despreader.sv
// 4-user Walsh-4 despreader: correlates the summed chip stream, decides one bit per user
// every 4 chips, emits 4 BITS-wide words per frame. Define CDMA_RX_ERRCNT_EN for err_count.
module cdma_rx_despreader #(
  parameter int CW   = 4,
  parameter int BITS = 4,
  parameter int ACW  = CW + 2
) (
  input  logic                 clk,
  input  logic                 rst,
  cdma_rx_despreader_if.slave  bus
);
  localparam int BW = (BITS > 1) ? $clog2(BITS) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(BITS - 1);
  // Bit c of WALSH[k] is chip c of user k+1; 1 means +1.
  localparam logic [3:0][3:0] WALSH = {4'b1001, 4'b0011, 4'b0101, 4'b1111};

  typedef enum logic {IDLE, RUN} state_t;

  state_t                  state;
  logic [1:0]              chip_idx;
  logic [BW-1:0]           bit_idx;
  logic [3:0][ACW-1:0]     acc;
  logic [3:0][BITS-2:0]    sh;
  logic [3:0][BITS-1:0]    word;
  logic                    amb;
  logic                    out_valid_q;
  logic                    frame_err_q;
  logic                    resync_q;

  logic                    start;
  logic                    take;
  logic [1:0]              ci;
  logic [BW-1:0]           bi;
  logic [ACW-1:0]          sext;
  logic [3:0][ACW-1:0]     acc_sum;
  logic [3:0]              dec;
  logic [3:0][BITS-1:0]    sh_n;
  logic                    amb_n;
  logic                    bit_end;
  logic                    frame_end;

  // A qualified sof always restarts from cleared state, so the current chip is
  // evaluated against zeroed indices, accumulators and flags in the same cycle.
  always_comb begin
    start   = bus.chip_valid && bus.chip_sof;
    take    = bus.chip_valid && (start || (state == RUN));
    ci      = start ? 2'd0 : chip_idx;
    bi      = start ? '0 : bit_idx;
    amb_n   = start ? 1'b0 : amb;
    sext    = {{(ACW-CW){bus.chip_sum[CW-1]}}, bus.chip_sum};
    acc_sum = '0;
    dec     = '0;
    sh_n    = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      acc_sum[k] = (start ? '0 : acc[k]) + (WALSH[k][ci] ? sext : -sext);
      dec[k]     = !acc_sum[k][ACW-1] && (acc_sum[k] != '0);
      sh_n[k]    = {(start ? '0 : sh[k]), dec[k]};
      if ((ci == 2'd3) && (acc_sum[k] == '0))
        amb_n = 1'b1;
    end
    bit_end   = take && (ci == 2'd3);
    frame_end = bit_end && (bi == LAST_BIT);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      chip_idx    <= '0;
      bit_idx     <= '0;
      acc         <= '0;
      sh          <= '0;
      word        <= '0;
      amb         <= 1'b0;
      out_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
      resync_q    <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      resync_q    <= start && (state == RUN);
      if (take) begin
        state <= RUN;
        amb   <= amb_n;
        if (frame_end) begin
          state       <= IDLE;
          chip_idx    <= '0;
          bit_idx     <= '0;
          acc         <= '0;
          sh          <= '0;
          amb         <= 1'b0;
          word        <= sh_n;
          out_valid_q <= 1'b1;
          frame_err_q <= amb_n;
        end else if (bit_end) begin
          chip_idx <= '0;
          bit_idx  <= bi + 1'b1;
          acc      <= '0;
          for (int unsigned k = 0; k < 4; k++)
            sh[k] <= sh_n[k][BITS-2:0];
        end else begin
          chip_idx <= ci + 2'd1;
          bit_idx  <= bi;
          acc      <= acc_sum;
          if (start)
            sh <= '0;
        end
      end
    end
  end

  assign bus.user1_out = word[0];
  assign bus.user2_out = word[1];
  assign bus.user3_out = word[2];
  assign bus.user4_out = word[3];
  assign bus.out_valid = out_valid_q;
  assign bus.frame_err = frame_err_q;
  assign bus.resync    = resync_q;

`ifdef CDMA_RX_ERRCNT_EN
  logic [7:0] err_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      err_cnt <= '0;
    else if (frame_end && amb_n && (err_cnt != 8'hFF))
      err_cnt <= err_cnt + 8'd1;
  end

  assign bus.err_count = err_cnt;
`else
  assign bus.err_count = '0;
`endif
endmodule

// File: tb/tb_cdma_rx_despreader.sv
// Randomized self-checking bench for cdma_rx_despreader; reference is a spreader plus
// integer correlator over whole frames.
module tb_cdma_rx_despreader;
  localparam int CW   = 4;
  localparam int BITS = 4;
  localparam int T    = 10;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cdma_rx_despreader_if #(.CW(CW), .BITS(BITS)) bus ();
  cdma_rx_despreader #(.CW(CW), .BITS(BITS), .ACW(CW + 2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int passed = 0;
  int total  = 0;

  int WS [4][4] = '{'{1, 1, 1, 1}, '{1, -1, 1, -1}, '{1, 1, -1, -1}, '{1, -1, -1, 1}};
  int          fr [16];
  logic [15:0] m_w;
  logic        m_err;
  int          exp_ec;
  time         last_t;
  time         sof_t;

  time         ov_t [$];
  logic [15:0] ov_w [$];
  logic        ov_e [$];
  time         rs_t [$];

  always @(negedge clk) begin
    if (bus.out_valid === 1'b1) begin
      ov_t.push_back($time);
      ov_w.push_back({bus.user1_out, bus.user2_out, bus.user3_out, bus.user4_out});
      ov_e.push_back(bus.frame_err);
    end
    if (bus.resync === 1'b1)
      rs_t.push_back($time);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1);
  end

  function automatic void clear_q();
    ov_t.delete();
    ov_w.delete();
    ov_e.delete();
    rs_t.delete();
  endfunction

  function automatic int ec_exp();
`ifdef CDMA_RX_ERRCNT_EN
    return exp_ec;
`else
    return 0;
`endif
  endfunction

  // Words packed user1..user4 from MSB; each user sends its word MSB first.
  function automatic void build_frame(input logic [15:0] w);
    for (int b = 0; b < 4; b++)
      for (int c = 0; c < 4; c++) begin
        int s = 0;
        for (int k = 0; k < 4; k++)
          s += (w[(3 - k) * 4 + (3 - b)] ? 1 : -1) * WS[k][c];
        fr[4 * b + c] = s;
      end
  endfunction

  function automatic void noise_frame();
    for (int i = 0; i < 16; i++)
      fr[i] = int'($urandom_range(0, 8)) - 4;
  endfunction

  function automatic void ref_decode();
    m_w   = '0;
    m_err = 1'b0;
    for (int b = 0; b < 4; b++)
      for (int k = 0; k < 4; k++) begin
        int corr = 0;
        for (int c = 0; c < 4; c++)
          corr += WS[k][c] * fr[4 * b + c];
        if (corr == 0) m_err = 1'b1;
        m_w[(3 - k) * 4 + (3 - b)] = (corr > 0);
      end
  endfunction

  task automatic drive(input logic v, input logic s, input int x);
    @(negedge clk);
    bus.chip_valid = v;
    bus.chip_sof   = s;
    bus.chip_sum   = x[CW-1:0];
  endtask

  task automatic send_frame(input int gap);
    for (int i = 0; i < 16; i++) begin
      if (gap > 0)
        repeat ($urandom_range(0, gap))
          drive(1'b0, 1'($urandom_range(0, 1)), int'($urandom_range(0, 8)) - 4);
      drive(1'b1, i == 0, fr[i]);
      if (i == 0) sof_t = $time;
    end
    last_t = $time;
    ref_decode();
    if (m_err && exp_ec < 255) exp_ec++;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.chip_valid = 1'b0;
    bus.chip_sof   = 1'b0;
    bus.chip_sum   = '0;
    exp_ec = 0;
    repeat (3) @(negedge clk);
    #1;
    total++;
    if ({bus.user1_out, bus.user2_out, bus.user3_out, bus.user4_out, bus.out_valid,
         bus.frame_err, bus.resync, bus.err_count} !== '0)
      $display("FAIL reset_init outputs got %h %h %h %h ov=%b fe=%b rs=%b ec=%0d required all 0",
               bus.user1_out, bus.user2_out, bus.user3_out, bus.user4_out,
               bus.out_valid, bus.frame_err, bus.resync, bus.err_count);
    else passed++;
    @(negedge clk);
    rst = 1'b1;

    build_frame(16'hA5C3);
    send_frame(0);
    build_frame(16'h3C5A);
    for (int i = 0; i < 7; i++) drive(1'b1, i == 0, fr[i]);
    #3 rst = 1'b0;
    #1;
    total++;
    if ({bus.user1_out, bus.user2_out, bus.user3_out, bus.user4_out, bus.out_valid,
         bus.frame_err, bus.resync, bus.err_count} !== '0)
      $display("FAIL reset_async outputs got %h %h %h %h ov=%b fe=%b rs=%b ec=%0d required all 0",
               bus.user1_out, bus.user2_out, bus.user3_out, bus.user4_out,
               bus.out_valid, bus.frame_err, bus.resync, bus.err_count);
    else passed++;
    exp_ec = 0;
    @(negedge clk);
    rst = 1'b1;
    #1 clear_q();

    for (int i = 0; i < 16; i++) drive(1'b1, 1'b0, fr[i]);
    drive(1'b0, 1'b0, 0);
    #1;
    total++;
    if (ov_t.size() != 0 || rs_t.size() != 0)
      $display("FAIL reset_nosof_ignored out_valid pulses=%0d resync pulses=%0d required 0 and 0",
               ov_t.size(), rs_t.size());
    else passed++;

    clear_q();
    build_frame(16'h9A6C);
    send_frame(0);
    drive(1'b0, 1'b0, 0);
    #1;
    total++;
    if (ov_t.size() != 1 || ov_w[0] !== 16'h9A6C)
      $display("FAIL reset_first_frame pulses=%0d word=%h required 1 and 9a6c",
               ov_t.size(), ov_w[0]);
    else passed++;
  endtask

  task automatic test_single_frame();
    clear_q();
    build_frame(16'hAC69);
    send_frame(0);
    drive(1'b0, 1'b0, 0);
    #1;
    total++;
    if (ov_t.size() != 1 || ov_t[0] != last_t + T)
      $display("FAIL single_latency pulses=%0d at %0t required 1 at %0t",
               ov_t.size(), ov_t[0], last_t + T);
    else passed++;
    total++;
    if (ov_w[0] !== 16'hAC69)
      $display("FAIL single_words got %h required ac69", ov_w[0]);
    else passed++;
    total++;
    if (ov_e[0] !== 1'b0)
      $display("FAIL single_frame_err got %b required 0", ov_e[0]);
    else passed++;
    drive(1'b0, 1'b0, 0);
    #1;
    total++;
    if (bus.out_valid !== 1'b0 ||
        {bus.user1_out, bus.user2_out, bus.user3_out, bus.user4_out} !== 16'hAC69)
      $display("FAIL single_hold ov=%b words=%h required 0 and ac69", bus.out_valid,
               {bus.user1_out, bus.user2_out, bus.user3_out, bus.user4_out});
    else passed++;
    total++;
    if (bus.err_count !== 8'(ec_exp()))
      $display("FAIL single_err_count got %0d required %0d", bus.err_count, ec_exp());
    else passed++;
  endtask

  task automatic test_back_to_back();
    logic [15:0] wa;
    time         ta;
    clear_q();
    wa = 16'($urandom);
    build_frame(wa);
    send_frame(0);
    ta = last_t;
    build_frame(16'hF0B5);
    send_frame(0);
    drive(1'b0, 1'b0, 0);
    #1;
    total++;
    if (ov_t.size() != 2 || ov_t[0] != ta + T || ov_t[1] - ov_t[0] != 16 * T)
      $display("FAIL b2b_timing pulses=%0d first=%0t gap=%0t required 2, %0t, %0t",
               ov_t.size(), ov_t[0], ov_t[1] - ov_t[0], ta + T, 16 * T);
    else passed++;
    total++;
    if (ov_w[0] !== wa || ov_w[1] !== 16'hF0B5 || ov_e[0] !== 1'b0 || ov_e[1] !== 1'b0)
      $display("FAIL b2b_words got %h/%b %h/%b required %h/0 f0b5/0",
               ov_w[0], ov_e[0], ov_w[1], ov_e[1], wa);
    else passed++;
  endtask

  task automatic test_stalls();
    for (int n = 0; n < 3; n++) begin
      logic [15:0] w = 16'($urandom);
      clear_q();
      build_frame(w);
      send_frame(3);
      drive(1'b0, 1'b0, 0);
      #1;
      total++;
      if (ov_t.size() != 1 || ov_t[0] != last_t + T)
        $display("FAIL stall_latency[%0d] pulses=%0d at %0t required 1 at %0t",
                 n, ov_t.size(), ov_t[0], last_t + T);
      else passed++;
      total++;
      if (ov_w[0] !== w || ov_e[0] !== 1'b0)
        $display("FAIL stall_words[%0d] got %h/%b required %h/0", n, ov_w[0], ov_e[0], w);
      else passed++;
    end
  endtask

  task automatic test_resync();
    logic [15:0] wy = 16'($urandom);
    clear_q();
    build_frame(16'($urandom));
    for (int i = 0; i < 7; i++) drive(1'b1, i == 0, fr[i]);
    build_frame(wy);
    send_frame(0);
    drive(1'b0, 1'b0, 0);
    #1;
    total++;
    if (rs_t.size() != 1 || rs_t[0] != sof_t + T)
      $display("FAIL resync_pulse count=%0d at %0t required 1 at %0t",
               rs_t.size(), rs_t[0], sof_t + T);
    else passed++;
    total++;
    if (ov_t.size() != 1 || ov_t[0] != last_t + T || ov_w[0] !== wy || ov_e[0] !== 1'b0)
      $display("FAIL resync_decode pulses=%0d word=%h err=%b required 1, %h, 0",
               ov_t.size(), ov_w[0], ov_e[0], wy);
    else passed++;
  endtask

  task automatic test_ambiguity();
    int bad = 0;
    clear_q();
    build_frame(16'($urandom));
    for (int i = 4; i < 8; i++) fr[i] = 0;
    send_frame(0);
    drive(1'b0, 1'b0, 0);
    #1;
    total++;
    if (ov_t.size() != 1 || ov_e[0] !== 1'b1)
      $display("FAIL amb_frame_err pulses=%0d err=%b required 1 and 1", ov_t.size(), ov_e[0]);
    else passed++;
    total++;
    if (ov_w[0] !== m_w || (ov_w[0] & 16'h4444) != 16'h0000)
      $display("FAIL amb_words got %h required %h with bit-1 positions 0", ov_w[0], m_w);
    else passed++;
    total++;
    if (bus.err_count !== 8'(ec_exp()))
      $display("FAIL amb_err_count got %0d required %0d", bus.err_count, ec_exp());
    else passed++;

    clear_q();
    for (int n = 0; n < 300; n++) send_frame(0);
    drive(1'b0, 1'b0, 0);
    #1;
    foreach (ov_e[i]) if (ov_e[i] !== 1'b1) bad++;
    total++;
    if (ov_t.size() != 300 || bad != 0)
      $display("FAIL amb_many pulses=%0d non-error frames=%0d required 300 and 0",
               ov_t.size(), bad);
    else passed++;
    total++;
    if (bus.err_count !== 8'(ec_exp()))
      $display("FAIL amb_saturate err_count got %0d required %0d", bus.err_count, ec_exp());
    else passed++;
  endtask

  task automatic test_random();
    logic [15:0] ew [$];
    logic        ee [$];
    clear_q();
    for (int n = 0; n < 24; n++) begin
      if ($urandom_range(0, 1) == 1) build_frame(16'($urandom));
      else noise_frame();
      send_frame($urandom_range(0, 1) == 1 ? 2 : 0);
      ew.push_back(m_w);
      ee.push_back(m_err);
    end
    drive(1'b0, 1'b0, 0);
    #1;
    total++;
    if (ov_t.size() != 24)
      $display("FAIL random_count pulses=%0d required 24", ov_t.size());
    else passed++;
    for (int i = 0; i < 24; i++) begin
      total++;
      if (ov_w[i] !== ew[i] || ov_e[i] !== ee[i])
        $display("FAIL random_frame[%0d] got %h/%b required %h/%b",
                 i, ov_w[i], ov_e[i], ew[i], ee[i]);
      else passed++;
    end
    total++;
    if (bus.err_count !== 8'(ec_exp()))
      $display("FAIL random_err_count got %0d required %0d", bus.err_count, ec_exp());
    else passed++;
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_stalls();
    test_resync();
    test_ambiguity();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/cdma_rx_despreader.md
Name: cdma_rx_despreader

Overview:
- Receive-side stage directly downstream of the 4-user CDMA spreader/channel summer.
- Consumes the summed chip stream, correlates it against the four length-4 Walsh codes, and decides one data bit per user every 4 chips.
- Reassembles each user's 4-bit word, MSB first, and presents all four words with a one-cycle valid pulse.
- Results feed the per-user output ports of the router.

Parameters:
- CW, 4, chip_sum width (signed two's complement); legal input range -4..+4.
- BITS, 4, data bits per user word (frame = BITS*4 chips).
- ACW, CW+2, correlator accumulator width (signed).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-low (0 = reset).
- chip_valid  in  1  chip_sum valid this cycle; no chip consumed when 0.
- chip_sof  in  1  first chip of a frame; qualified by chip_valid.
- chip_sum  in  CW  signed sum of the four users' +/-1 chips.
- user1_out  out  4  decoded word, user 1.
- user2_out  out  4  decoded word, user 2.
- user3_out  out  4  decoded word, user 3.
- user4_out  out  4  decoded word, user 4.
- out_valid  out  1  one-cycle pulse; userN_out are new this cycle.
- frame_err  out  1  valid with out_valid; 1 if any correlation in the frame was exactly 0.
- resync  out  1  one-cycle pulse; a frame was aborted by an early chip_sof.
- err_count  out  8  count of frames with frame_err (see Optional Feature).

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; chip index, bit index, accumulators and shift registers cleared; all outputs 0.
- Walsh codes, chip order 0..3, 1 = +1:
  - U1 = + + + +
  - U2 = + - + -
  - U3 = + + - -
  - U4 = + - - +
- FSM states: IDLE, RUN.
  - IDLE: chips are ignored until chip_valid=1 and chip_sof=1. That chip is chip 0 of bit 0 and is accumulated in the same cycle; go to RUN.
  - RUN: each chip_valid cycle accumulates acc_k += code_k[chip_idx] ? chip_sum : -chip_sum, using sign-extension to ACW.
  - RUN, chip_valid=0: stall; no state change.
- Bit decision, after chip 3:
  - bit_k = (acc_k > 0).
  - acc_k == 0 gives bit 0 and sets the frame's ambiguous flag.
  - Accumulators clear for the next bit.
  - The bit is shifted into the user's word, MSB first.
- Frame completion, after chip 3 of bit BITS-1:
  - Next cycle: userN_out are updated, out_valid=1, and frame_err = ambiguous flag.
  - Latency: out_valid is asserted exactly 1 cycle after the 16th accepted chip.
  - FSM returns to IDLE.
  - userN_out hold their value until the next frame completes.
- Back-to-back frames: a chip_valid+chip_sof in the cycle after the 16th chip starts a new frame with no lost chip. Accumulation uses fresh cleared state.
- chip_sof while in RUN at any chip other than the 16th-chip boundary:
  - Discard the partial frame; pulse resync the next cycle.
  - Restart with this chip as chip 0 of bit 0.
  - userN_out and out_valid are unaffected.
- chip_sof with chip_valid=0 is ignored.
- Input outside -4..+4 is not checked; arithmetic wraps only within ACW, so valid inputs never overflow (|acc| <= 16).

Optional Feature:
- Macro CDMA_RX_ERRCNT_EN.
- Defined: err_count is an 8-bit counter.
  - Increments in the cycle out_valid=1 with frame_err=1.
  - Saturates at 255.
  - Reset to 0 by rst.
- Undefined: err_count is tied to 0; no counter logic is synthesized.

Test Plan:
- Reset: assert rst=0 mid-frame, then release -> all outputs 0, FSM in IDLE; the next chip without sof is ignored.
- Single frame, user words 1010/1100/0110/1001:
  - Stimulus: sof on the first chip; bit-0 chips 2,-2,2,2; remaining chips from the spreader model.
  - Response: one cycle after chip 16, out_valid=1 and outputs 1010, 1100, 0110, 1001; frame_err=0.
- Back-to-back frames:
  - Second frame 1111/0000/1011/0101 sent with sof the cycle after chip 16 of the first frame.
  - Response: two out_valid pulses exactly 16 cycles apart; outputs match each frame.
- Stalls: insert random chip_valid=0 gaps -> same decoded words; out_valid 1 cycle after the last valid chip.
- Resync: sof at chip 7 -> resync pulse the next cycle; the following 16 chips decode correctly; no out_valid for the aborted frame.
- Ambiguity: frame containing an all-zero bit period (chips 0,0,0,0) -> bit decided 0, frame_err=1 with out_valid.
  - With CDMA_RX_ERRCNT_EN: err_count increments 0 -> 1.
  - After 300 error frames: err_count = 255.
